// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Iterative unsigned MULTU/DIVU engine that owns the HI/LO register pair.
// Multiply is shift-add, divide is restoring, and each takes WIDTH RUN cycles.
// DIVU by zero completes in one cycle with hi = dividend and lo = all-ones.
// MFHI/MFLO reads are combinational. Reads stall while an operation is in flight.

module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic [1:0]       lh_sel,
    output logic [WIDTH-1:0] lh_data,
    output logic             busy,
    output logic             lh_stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               div_r;       // latched operation kind
    logic [WIDTH-1:0]   opnd_r;      // multiplicand or divisor
    logic [WIDTH-1:0]   acc_hi_r;    // product upper half or partial remainder
    logic [WIDTH-1:0]   acc_lo_r;    // multiplier/product lower half or quotient
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   acc_hi_nxt_s;
    logic [WIDTH-1:0]   acc_lo_nxt_s;
    logic [WIDTH-1:0]   lh_data_s;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // One iteration of the shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s    = {1'b0, acc_hi_r};
        rem_sh_s     = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s   = rem_sh_s[WIDTH-1:0] - opnd_r;
        div_ge_s     = (rem_sh_s >= {1'b0, opnd_r});
        acc_hi_nxt_s = acc_hi_r;
        acc_lo_nxt_s = acc_lo_r;
        if (acc_lo_r[0]) begin
            mul_sum_s = {1'b0, acc_hi_r} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_hi_r};
        end
        if (div_r) begin
            // The remainder always stays below the divisor, so WIDTH bits hold it.
            if (div_ge_s) begin
                acc_hi_nxt_s = div_diff_s;
                acc_lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_nxt_s = rem_sh_s[WIDTH-1:0];
                acc_lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_nxt_s = mul_sum_s[WIDTH:1];
            acc_lo_nxt_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sequencer FSM with its datapath registers and registered busy/done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            div_r    <= 1'b0;
            opnd_r   <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state_r <= ST_IDLE;
                    // A flush in the same cycle suppresses the request.
                    if (start && !flush) begin
                        if (div_sel && (op_b == {WIDTH{1'b0}})) begin
                            state_r <= ST_DONE;
                            hi_r    <= op_a;
                            lo_r    <= {WIDTH{1'b1}};
                            done_r  <= 1'b1;
                        end else begin
                            state_r  <= ST_RUN;
                            busy_r   <= 1'b1;
                            cnt_r    <= {CNT_W{1'b0}};
                            div_r    <= div_sel;
                            acc_hi_r <= {WIDTH{1'b0}};
                            if (div_sel) begin
                                opnd_r   <= op_b;
                                acc_lo_r <= op_a;
                            end else begin
                                opnd_r   <= op_a;
                                acc_lo_r <= op_b;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    done_r <= 1'b0;
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        acc_hi_r <= acc_hi_nxt_s;
                        acc_lo_r <= acc_lo_nxt_s;
                        if (cnt_r == LAST_ITER) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            hi_r    <= acc_hi_nxt_s;
                            lo_r    <= acc_lo_nxt_s;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // MFHI/MFLO read mux; the reserved encoding reads as zero.
    always_comb begin
        lh_data_s = {WIDTH{1'b0}};
        case (lh_sel)
            2'b01:   lh_data_s = lo_r;
            2'b10:   lh_data_s = hi_r;
            default: lh_data_s = {WIDTH{1'b0}};
        endcase
    end

    assign lh_data  = lh_data_s;
    assign lh_stall = busy_r & (lh_sel != 2'b00);
    assign busy     = busy_r;
    assign done     = done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         div_sel;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic [1:0]   lh_sel;
    logic [W-1:0] lh_data;
    logic         busy;
    logic         lh_stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .div_sel  (div_sel),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .lh_sel   (lh_sel),
        .lh_data  (lh_data),
        .busy     (busy),
        .lh_stall (lh_stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns one step after acceptance edge.
    task automatic issue(input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
        start   = 1'b1;
        div_sel = d;
        op_a    = a;
        op_b    = b;
        step();
        start   = 1'b0;
    endtask

    // Count busy samples until done is seen, bounded to 40 cycles.
    task automatic wait_done(output int bc, output bit seen);
        bc   = 0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy === 1'b1) bc++;
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", hi); end
        tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", lo); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mult_max();
        int bc;
        bit seen;
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, seen);
        tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL mult_max_done_timeout: got %b expected 1", seen); end
        tests_run++; if (bc != 32) begin tests_failed++; $display("FAIL mult_max_busy_cycles: got %0d expected 32", bc); end
        tests_run++; if (hi !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mult_max_hi: got %h expected fffffffe", hi); end
        tests_run++; if (lo !== 32'h0000_0001) begin tests_failed++; $display("FAIL mult_max_lo: got %h expected 00000001", lo); end
        lh_sel = 2'b10;
        #1;
        tests_run++; if (lh_data !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mult_max_mfhi: got %h expected fffffffe", lh_data); end
        lh_sel = 2'b00;
        step();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mult_max_single_pulse: got %b expected 0", done); end
    endtask

    task automatic test_div_back_to_back();
        int bc;
        bit seen;
        issue(1'b1, 32'd100, 32'd7);
        wait_done(bc, seen);
        tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL div_done_timeout: got %b expected 1", seen); end
        tests_run++; if (bc != 32) begin tests_failed++; $display("FAIL div_busy_cycles: got %0d expected 32", bc); end
        tests_run++; if (lo !== 32'd14) begin tests_failed++; $display("FAIL div_quot: got %0d expected 14", lo); end
        tests_run++; if (hi !== 32'd2) begin tests_failed++; $display("FAIL div_rem: got %0d expected 2", hi); end
        // Issue next op in the DONE cycle.
        issue(1'b0, 32'd3, 32'd5);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got %b expected 1", busy); end
        wait_done(bc, seen);
        tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_timeout: got %b expected 1", seen); end
        tests_run++; if (bc != 32) begin tests_failed++; $display("FAIL b2b_busy_cycles: got %0d expected 32", bc); end
        tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL b2b_hi: got %h expected 0", hi); end
        tests_run++; if (lo !== 32'd15) begin tests_failed++; $display("FAIL b2b_lo: got %0d expected 15", lo); end
        step();
    endtask

    task automatic test_div_zero();
        issue(1'b1, 32'h1234_5678, 32'h0);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL div0_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL div0_done: got %b expected 1", done); end
        tests_run++; if (hi !== 32'h1234_5678) begin tests_failed++; $display("FAIL div0_hi: got %h expected 12345678", hi); end
        tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
        step();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL div0_done_clear: got %b expected 0", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL div0_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_ignored_start();
        int bc;
        int dc;
        bc = 0;
        dc = 0;
        issue(1'b0, 32'd6, 32'd7);
        for (int i = 1; i <= 40; i++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) dc++;
            if (i == 10) begin
                start   = 1'b1;
                div_sel = 1'b1;
                op_a    = 32'd9;
                op_b    = 32'd3;
            end
            step();
            start = 1'b0;
        end
        tests_run++; if (bc != 32) begin tests_failed++; $display("FAIL ignore_busy_cycles: got %0d expected 32", bc); end
        tests_run++; if (dc != 1) begin tests_failed++; $display("FAIL ignore_done_count: got %0d expected 1", dc); end
        tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL ignore_hi: got %h expected 0", hi); end
        tests_run++; if (lo !== 32'd42) begin tests_failed++; $display("FAIL ignore_lo: got %0d expected 42", lo); end
    endtask

    task automatic test_flush_and_reset();
        int dc;
        dc = 0;
        issue(1'b0, 32'd2, 32'd2);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b expected 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dc++;
            step();
        end
        tests_run++; if (dc != 0) begin tests_failed++; $display("FAIL flush_no_done: got %0d expected 0", dc); end
        tests_run++; if (lo !== 32'd42) begin tests_failed++; $display("FAIL flush_lo: got %0d expected 42", lo); end
        tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL flush_hi: got %h expected 0", hi); end
        // Flush and start together in IDLE: start is dropped.
        start   = 1'b1;
        flush   = 1'b1;
        div_sel = 1'b0;
        op_a    = 32'd2;
        op_b    = 32'd2;
        step();
        start = 1'b0;
        flush = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
        // Asynchronous reset mid-operation.
        issue(1'b0, 32'd2, 32'd2);
        repeat (19) step();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
        tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL rst_async_hi: got %h expected 0", hi); end
        tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL rst_async_lo: got %0d expected 0", lo); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stall();
        int bc;
        bit seen;
        issue(1'b0, 32'd3, 32'd5);
        wait_done(bc, seen);
        step();
        issue(1'b0, 32'd7, 32'd9);
        lh_sel = 2'b01;
        #1;
        bc   = 0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                tests_run++; if (lh_stall !== 1'b0) begin tests_failed++; $display("FAIL stall_done_cycle: got %b expected 0", lh_stall); end
                tests_run++; if (lh_data !== 32'd63) begin tests_failed++; $display("FAIL stall_done_data: got %0d expected 63", lh_data); end
            end else begin
                if (busy === 1'b1) begin
                    bc++;
                    tests_run++; if (lh_stall !== 1'b1) begin tests_failed++; $display("FAIL stall_run_cycle%0d: got %b expected 1", bc, lh_stall); end
                    tests_run++; if (lh_data !== 32'd15) begin tests_failed++; $display("FAIL stall_old_data%0d: got %0d expected 15", bc, lh_data); end
                end
                step();
            end
        end
        tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL stall_done_timeout: got %b expected 1", seen); end
        tests_run++; if (bc != 32) begin tests_failed++; $display("FAIL stall_busy_cycles: got %0d expected 32", bc); end
        lh_sel = 2'b11;
        #1;
        tests_run++; if (lh_data !== 32'd0) begin tests_failed++; $display("FAIL reserved_read: got %h expected 0", lh_data); end
        tests_run++; if (lh_stall !== 1'b0) begin tests_failed++; $display("FAIL reserved_stall: got %b expected 0", lh_stall); end
        lh_sel = 2'b00;
        step();
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        div_sel = 1'b0;
        op_a    = 32'h0;
        op_b    = 32'h0;
        flush   = 1'b0;
        lh_sel  = 2'b00;
        test_reset();
        test_mult_max();
        test_div_back_to_back();
        test_div_zero();
        test_ignored_start();
        test_flush_and_reset();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
